// File: rtl/tank_level_model_pkg.sv
// Shared definitions for the tank plant model: sensor/pump bit positions and flow classification.
// The pump-control FSM imports the same bit positions, so the two sides cannot disagree.
package tank_level_model_pkg;

    localparam int unsigned SensorI = 0;
    localparam int unsigned SensorS = 1;
    localparam int unsigned PumpB1  = 0;
    localparam int unsigned PumpB2  = 1;

    typedef enum logic [1:0] {
        FlowInRange,
        FlowOver,
        FlowUnder
    } flow_e;

    function automatic logic [1:0] active_pumps(input logic [1:0] pumps);
        return {1'b0, pumps[PumpB1]} + {1'b0, pumps[PumpB2]};
    endfunction

endpackage

// File: rtl/tank_level_model_tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and raises tick while at the last count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == CntLast) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign tick = (count_q == CntLast);

endmodule

// File: rtl/tank_level_model.sv
// Simulated water tank: integrates pump inflow and drain outflow once per tick, saturates at
// 0 and LEVEL_MAX with sticky flags, and drives the registered I/S level sensors.
module tank_level_model #(
    parameter int unsigned LEVEL_WIDTH = 8,
    parameter int unsigned LEVEL_MAX   = 200,
    parameter int unsigned LEVEL_LOW   = 60,
    parameter int unsigned LEVEL_HIGH  = 160,
    parameter int unsigned INIT_LEVEL  = 0,
    parameter int unsigned PUMP_RATE   = 2,
    parameter int unsigned DRAIN_RATE  = 1,
    parameter int unsigned TICK_DIV    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             pumps,
    input  logic                   drain_enable,
    output logic [1:0]             level_sensors,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   tick,
    output logic                   overflow,
    output logic                   dry
);

    import tank_level_model_pkg::*;

    // Two extra bits give headroom above LEVEL_MAX and a sign bit for underflow.
    localparam int unsigned SumW = LEVEL_WIDTH + 2;

    localparam logic signed [SumW-1:0] MaxS   = SumW'(LEVEL_MAX);
    localparam logic signed [SumW-1:0] PumpS  = SumW'(PUMP_RATE);
    localparam logic signed [SumW-1:0] DrainS = SumW'(DRAIN_RATE);
    localparam logic signed [SumW-1:0] ZeroS  = '0;

    localparam logic [LEVEL_WIDTH-1:0] LevelMax  = LEVEL_WIDTH'(LEVEL_MAX);
    localparam logic [LEVEL_WIDTH-1:0] LevelLow  = LEVEL_WIDTH'(LEVEL_LOW);
    localparam logic [LEVEL_WIDTH-1:0] LevelHigh = LEVEL_WIDTH'(LEVEL_HIGH);
    localparam logic [LEVEL_WIDTH-1:0] LevelInit = LEVEL_WIDTH'(INIT_LEVEL);

    localparam logic InitI = (INIT_LEVEL >= LEVEL_LOW);
    localparam logic InitS = (INIT_LEVEL >= LEVEL_HIGH);

    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [1:0]             sensors_q, sensors_d;
    logic                   overflow_q, overflow_d;
    logic                   dry_q, dry_d;
    logic signed [SumW-1:0] sum;
    flow_e                  flow;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        sum = $signed({2'b00, level_q})
            + $signed(SumW'(active_pumps(pumps))) * PumpS
            - (drain_enable ? DrainS : ZeroS);

        if (sum > MaxS) begin
            flow = FlowOver;
        end else if (sum < ZeroS) begin
            flow = FlowUnder;
        end else begin
            flow = FlowInRange;
        end
    end

    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        dry_d      = dry_q;

        if (tick) begin
            case (flow)
                FlowOver: begin
                    level_d    = LevelMax;
                    overflow_d = 1'b1;
                end
                FlowUnder: begin
                    level_d = '0;
                    dry_d   = 1'b1;
                end
                default: level_d = sum[LEVEL_WIDTH-1:0];
            endcase
        end

        // Sensors follow the current register, so they lag a level change by one cycle.
        sensors_d          = '0;
        sensors_d[SensorI] = (level_q >= LevelLow);
        sensors_d[SensorS] = (level_q >= LevelHigh);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q            <= LevelInit;
            overflow_q         <= 1'b0;
            dry_q              <= 1'b0;
            sensors_q          <= '0;
            sensors_q[SensorI] <= InitI;
            sensors_q[SensorS] <= InitS;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dry_q      <= dry_d;
            sensors_q  <= sensors_d;
        end
    end

    assign level         = level_q;
    assign level_sensors = sensors_q;
    assign overflow      = overflow_q;
    assign dry           = dry_q;

endmodule

// File: tb/tb_tank_level_model.sv
// Self-checking bench for tank_level_model: vector table, directed corner sequences,
// random stimulus against an arithmetic model, and a closed loop with a hysteresis controller.
module tb_tank_level_model;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       rst    [3];
    logic [1:0] pumps  [3];
    logic       drain  [3];
    logic [1:0] sens   [3];
    logic [7:0] lvl    [3];
    logic       tk     [3];
    logic       ov     [3];
    logic       dr     [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tank_level_model #(.INIT_LEVEL(0)) dut0 (
        .clock(clock), .reset(rst[0]), .pumps(pumps[0]), .drain_enable(drain[0]),
        .level_sensors(sens[0]), .level(lvl[0]), .tick(tk[0]), .overflow(ov[0]), .dry(dr[0])
    );
    tank_level_model #(.INIT_LEVEL(60)) dut1 (
        .clock(clock), .reset(rst[1]), .pumps(pumps[1]), .drain_enable(drain[1]),
        .level_sensors(sens[1]), .level(lvl[1]), .tick(tk[1]), .overflow(ov[1]), .dry(dr[1])
    );
    tank_level_model #(.INIT_LEVEL(1)) dut2 (
        .clock(clock), .reset(rst[2]), .pumps(pumps[2]), .drain_enable(drain[2]),
        .level_sensors(sens[2]), .level(lvl[2]), .tick(tk[2]), .overflow(ov[2]), .dry(dr[2])
    );

    // S without I is never legal on any instance.
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (sens[d][1] === 1'b1 && sens[d][0] !== 1'b1) begin
                errors++;
                $display("FAIL sensor_monotone dut%0d: sensors=%b required S->I", d, sens[d]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        rst[d] = 1'b0;
    endtask

    // Wait for the tick cycle, then step past the integrating edge.
    task automatic step_tick(input int d);
        int n = 0;
        while (tk[d] !== 1'b1 && n < 16) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("tick_wait", 32'(tk[d]), 1);
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [1:0] p;
        logic       dn;
        int         exp_level;
        logic       exp_dry;
    } vec_t;

    vec_t vecs[8];
    int   m_level, m_cnt, m_nxt, m_sum, n;
    logic [1:0] m_sens, rp;
    logic m_ov, m_dry, rdn, rr, filling;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]   = 1'b1;
            pumps[d] = 2'b00;
            drain[d] = 1'b0;
        end

        // One tick per entry starting from reset (level 0).
        vecs[0] = '{2'b11, 1'b0, 4, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 6, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 7, 1'b0};
        vecs[3] = '{2'b00, 1'b1, 6, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 9, 1'b0};
        vecs[5] = '{2'b00, 1'b0, 9, 1'b0};
        vecs[6] = '{2'b00, 1'b1, 8, 1'b0};
        vecs[7] = '{2'b10, 1'b0, 10, 1'b0};
        do_reset(0);
        chk("vec_reset_level", 32'(lvl[0]), 0);
        for (int i = 0; i < 8; i++) begin
            pumps[0] = vecs[i].p;
            drain[0] = vecs[i].dn;
            step_tick(0);
            chk($sformatf("vec%0d_level", i), 32'(lvl[0]), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_dry", i), 32'(dr[0]), 32'(vecs[i].exp_dry));
        end

        // Fill from empty with both pumps.
        pumps[0] = 2'b11;
        drain[0] = 1'b0;
        do_reset(0);
        chk("rst_level", 32'(lvl[0]), 0);
        chk("rst_sensors", 32'(sens[0]), 0);
        chk("rst_tick", 32'(tk[0]), 0);
        chk("rst_ovf", 32'(ov[0]), 0);
        chk("rst_dry", 32'(dr[0]), 0);
        for (int k = 1; k <= 50; k++) begin
            step_tick(0);
            chk($sformatf("fill_level_t%0d", k), 32'(lvl[0]), 32'(4 * k));
            if (k == 15) begin
                chk("i_lag", 32'(sens[0]), 0);
                @(posedge clock);
                #1;
                chk("i_set", 32'(sens[0]), 1);
            end
            if (k == 40) begin
                chk("s_lag", 32'(sens[0]), 1);
                @(posedge clock);
                #1;
                chk("s_set", 32'(sens[0]), 3);
            end
        end
        chk("exact_max_no_ovf", 32'(ov[0]), 0);
        step_tick(0);
        chk("sat_level", 32'(lvl[0]), 200);
        chk("ovf_set", 32'(ov[0]), 1);
        pumps[0] = 2'b00;
        step_tick(0);
        step_tick(0);
        chk("ovf_sticky", 32'(ov[0]), 1);
        chk("hold_level", 32'(lvl[0]), 200);

        // Drain down to 100, then reset mid-count.
        drain[0] = 1'b1;
        for (int k = 0; k < 100; k++) step_tick(0);
        chk("drain_to_100", 32'(lvl[0]), 100);
        chk("ovf_still", 32'(ov[0]), 1);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        rst[0] = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_level", 32'(lvl[0]), 0);
        chk("midrst_ovf", 32'(ov[0]), 0);
        chk("midrst_sensors", 32'(sens[0]), 0);
        chk("midrst_tick", 32'(tk[0]), 0);
        rst[0] = 1'b0;
        n = 0;
        while (tk[0] !== 1'b1 && n < 16) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("midrst_first_tick", 32'(n), 3);

        // INIT_LEVEL=60 draining; pumps between ticks are ignored.
        drain[1] = 1'b1;
        do_reset(1);
        chk("i60_level", 32'(lvl[1]), 60);
        chk("i60_sensors", 32'(sens[1]), 1);
        step_tick(1);
        chk("i60_t1_level", 32'(lvl[1]), 59);
        chk("i60_i_lag", 32'(sens[1]), 1);
        @(posedge clock);
        #1;
        chk("i60_i_fall", 32'(sens[1]), 0);
        pumps[1] = 2'b11;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        pumps[1] = 2'b00;
        step_tick(1);
        chk("i60_ignore_pumps", 32'(lvl[1]), 58);

        // INIT_LEVEL=1: exact zero is not dry, going below is.
        drain[2] = 1'b1;
        do_reset(2);
        chk("i1_level", 32'(lvl[2]), 1);
        step_tick(2);
        chk("i1_t1_level", 32'(lvl[2]), 0);
        chk("i1_t1_dry", 32'(dr[2]), 0);
        step_tick(2);
        chk("i1_t2_level", 32'(lvl[2]), 0);
        chk("i1_t2_dry", 32'(dr[2]), 1);
        step_tick(2);
        chk("i1_dry_sticky", 32'(dr[2]), 1);

        // Random stimulus against the arithmetic model.
        do_reset(0);
        m_level = 0; m_cnt = 0; m_sens = 2'b00; m_ov = 1'b0; m_dry = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rp  = 2'($urandom_range(0, 3));
            rdn = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 200) == 0);
            pumps[0] = rp;
            drain[0] = rdn;
            rst[0]   = rr;
            @(posedge clock);
            if (rr) begin
                m_level = 0; m_cnt = 0; m_sens = 2'b00; m_ov = 1'b0; m_dry = 1'b0;
            end else begin
                m_nxt = m_level;
                if (m_cnt == TD - 1) begin
                    m_sum = m_level + $countones(rp) * 2 - (rdn ? 1 : 0);
                    if (m_sum > 200) begin
                        m_nxt = 200; m_ov = 1'b1;
                    end else if (m_sum < 0) begin
                        m_nxt = 0; m_dry = 1'b1;
                    end else begin
                        m_nxt = m_sum;
                    end
                end
                m_sens  = {1'(m_level >= 160), 1'(m_level >= 60)};
                m_level = m_nxt;
                m_cnt   = (m_cnt + 1) % TD;
            end
            #1;
            chk($sformatf("rnd%0d_level", c), 32'(lvl[0]), 32'(m_level));
            chk($sformatf("rnd%0d_sensors", c), 32'(sens[0]), 32'(m_sens));
            chk($sformatf("rnd%0d_tick", c), 32'(tk[0]), 32'(m_cnt == TD - 1));
            chk($sformatf("rnd%0d_ovf", c), 32'(ov[0]), 32'(m_ov));
            chk($sformatf("rnd%0d_dry", c), 32'(dr[0]), 32'(m_dry));
        end
        rst[0] = 1'b0;

        // Closed loop: fill when I drops, stop when S rises, constant drain.
        pumps[0] = 2'b00;
        drain[0] = 1'b1;
        do_reset(0);
        filling = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (sens[0][0] == 1'b0) filling = 1'b1;
            else if (sens[0][1] == 1'b1) filling = 1'b0;
            pumps[0] = filling ? 2'b11 : 2'b00;
            @(posedge clock);
            #1;
            chk("loop_range", 32'(lvl[0] <= 8'd200), 1);
        end
        chk("loop_ovf", 32'(ov[0]), 0);
        chk("loop_dry", 32'(dr[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
